core_datapath: RTL and testbench

CORE_DATAPATH -- requirements
Module: core_datapath

---
 rtl/core_datapath.sv | 206 ++++++++++++++++++++
 tb/tb_core_datapath.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_datapath.sv
// core_datapath: single-bus register datapath with one-hot source/target enables
// and a request/acknowledge memory port. Register moves complete in one cycle;
// memory reads and writes hold the bus port busy until the memory acknowledges.
module core_datapath #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [15:0]           i_unit_ien,
    input  logic [15:0]           i_unit_oen,
    input  logic [DATA_WIDTH-1:0] i_alu_re,
    output logic [DATA_WIDTH-1:0] o_ins,
    output logic [DATA_WIDTH-1:0] o_alu_a,
    output logic [DATA_WIDTH-1:0] o_alu_b,
    output logic [DATA_WIDTH-1:0] o_alu_op,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic                  o_mem_req,
    output logic                  o_mem_we,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    input  logic                  i_mem_ack,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata,
    output logic                  o_busy,
    output logic                  o_err
);

    // Enable bit positions shared by source and target words.
    localparam int unsigned UIr     = 1;
    localparam int unsigned UPc     = 2;
    localparam int unsigned UAr     = 3;
    localparam int unsigned UDr0    = 4;
    localparam int unsigned UDr1    = 5;
    localparam int unsigned UCr     = 6;
    localparam int unsigned UDr2    = 7;
    localparam int unsigned UAluRe  = 8;
    localparam int unsigned UAluAd  = 9;
    localparam int unsigned UMemPc  = 12;
    localparam int unsigned UMemAr  = 13;

    typedef enum logic [1:0] {StIdle, StMemRd, StMemWr} state_e;

    // Only the targets that hold state; NULL-style targets simply drop data.
    typedef struct packed {
        logic op;
        logic dr2;
        logic cr;
        logic dr1;
        logic dr0;
        logic ar;
        logic pc;
        logic ir;
    } wsel_t;

    state_e                state_q;
    logic [DATA_WIDTH-1:0] ir_q, dr0_q, dr1_q, dr2_q, cr_q, op_q, mem_wdata_q;
    logic [ADDR_WIDTH-1:0] pc_q, ar_q, mem_addr_q;
    logic                  mem_req_q, mem_we_q, err_q, use_pc_q;
    wsel_t                 tgt_q;

    logic                  ien_ok, oen_ok, legal, src_mem, tgt_mem;
    logic [DATA_WIDTH-1:0] bus;
    wsel_t                 ien_sel;
    wsel_t                 wr_sel;
    logic [DATA_WIDTH-1:0] wr_val;
    logic                  pc_inc;

    // Decode the enable words and build the bus as a one-hot AND-OR mux.
    always_comb begin
        ien_ok  = (i_unit_ien != 16'd0) && ((i_unit_ien & (i_unit_ien - 16'd1)) == 16'd0);
        oen_ok  = (i_unit_oen != 16'd0) && ((i_unit_oen & (i_unit_oen - 16'd1)) == 16'd0);
        src_mem = i_unit_oen[UMemPc] | i_unit_oen[UMemAr];
        tgt_mem = i_unit_ien[UMemPc] | i_unit_ien[UMemAr];
        legal   = ien_ok && oen_ok && !(src_mem && tgt_mem);

        ien_sel.ir  = i_unit_ien[UIr];
        ien_sel.pc  = i_unit_ien[UPc];
        ien_sel.ar  = i_unit_ien[UAr];
        ien_sel.dr0 = i_unit_ien[UDr0];
        ien_sel.dr1 = i_unit_ien[UDr1];
        ien_sel.cr  = i_unit_ien[UCr];
        ien_sel.dr2 = i_unit_ien[UDr2];
        ien_sel.op  = i_unit_ien[UAluAd];

        bus = ({DATA_WIDTH{i_unit_oen[UIr]}}    & ir_q)
            | ({DATA_WIDTH{i_unit_oen[UPc]}}    & DATA_WIDTH'(pc_q))
            | ({DATA_WIDTH{i_unit_oen[UAr]}}    & DATA_WIDTH'(ar_q))
            | ({DATA_WIDTH{i_unit_oen[UDr0]}}   & dr0_q)
            | ({DATA_WIDTH{i_unit_oen[UDr1]}}   & dr1_q)
            | ({DATA_WIDTH{i_unit_oen[UCr]}}    & cr_q)
            | ({DATA_WIDTH{i_unit_oen[UDr2]}}   & dr2_q)
            | ({DATA_WIDTH{i_unit_oen[UAluRe]}} & i_alu_re);
    end

    // Select which register (if any) is written this cycle and whether PC steps.
    always_comb begin
        wr_sel = '0;
        wr_val = bus;
        pc_inc = 1'b0;
        case (state_q)
            StIdle: begin
                if (legal && !src_mem && !tgt_mem) begin
                    wr_sel = ien_sel;
                end
            end
            StMemRd: begin
                if (i_mem_ack) begin
                    wr_sel = tgt_q;
                    wr_val = i_mem_rdata;
                    // An explicit PC load from memory overrides the auto-increment.
                    pc_inc = use_pc_q & ~tgt_q.pc;
                end
            end
            StMemWr: begin
                if (i_mem_ack) begin
                    pc_inc = use_pc_q;
                end
            end
            default: ;
        endcase
    end

    // Transfer control FSM with registered memory-port outputs and error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            mem_addr_q  <= '0;
            tgt_q       <= '0;
            use_pc_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (!legal) begin
                        err_q <= 1'b1;
                    end else if (src_mem) begin
                        state_q    <= StMemRd;
                        mem_req_q  <= 1'b1;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= i_unit_oen[UMemPc] ? pc_q : ar_q;
                        use_pc_q   <= i_unit_oen[UMemPc];
                        tgt_q      <= ien_sel;
                    end else if (tgt_mem) begin
                        state_q     <= StMemWr;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b1;
                        mem_wdata_q <= bus;
                        mem_addr_q  <= i_unit_ien[UMemPc] ? pc_q : ar_q;
                        use_pc_q    <= i_unit_ien[UMemPc];
                        tgt_q       <= '0;
                    end
                end
                StMemRd, StMemWr: begin
                    // Enables are ignored here; only the acknowledge moves us on.
                    if (i_mem_ack) begin
                        state_q   <= StIdle;
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Architectural registers, written from the bus or from memory read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            ir_q  <= '0;
            pc_q  <= '0;
            ar_q  <= '0;
            dr0_q <= '0;
            dr1_q <= '0;
            dr2_q <= '0;
            cr_q  <= '0;
            op_q  <= '0;
        end else begin
            if (wr_sel.ir)  ir_q  <= wr_val;
            if (wr_sel.ar)  ar_q  <= ADDR_WIDTH'(wr_val);
            if (wr_sel.dr0) dr0_q <= wr_val;
            if (wr_sel.dr1) dr1_q <= wr_val;
            if (wr_sel.dr2) dr2_q <= wr_val;
            if (wr_sel.cr)  cr_q  <= wr_val;
            if (wr_sel.op)  op_q  <= wr_val;
            if (wr_sel.pc) begin
                pc_q <= ADDR_WIDTH'(wr_val);
            end else if (pc_inc) begin
                pc_q <= pc_q + ADDR_WIDTH'(1);
            end
        end
    end

    assign o_ins       = ir_q;
    assign o_alu_a     = dr0_q;
    assign o_alu_b     = dr1_q;
    assign o_alu_op    = op_q;
    assign o_mem_addr  = mem_addr_q;
    assign o_mem_req   = mem_req_q;
    assign o_mem_we    = mem_we_q;
    assign o_mem_wdata = mem_wdata_q;
    assign o_busy      = (state_q != StIdle);
    assign o_err       = err_q;

endmodule

// File: tb/tb_core_datapath.sv
// tb_core_datapath: vector table for register moves plus hand-written memory
// sequences; memory expectations are queued when a request is issued and
// popped when the DUT raises o_mem_req.
module tb_core_datapath;

    localparam logic [15:0] E_NULL  = 16'h0001;
    localparam logic [15:0] E_IR    = 16'h0002;
    localparam logic [15:0] E_PC    = 16'h0004;
    localparam logic [15:0] E_AR    = 16'h0008;
    localparam logic [15:0] E_DR0   = 16'h0010;
    localparam logic [15:0] E_DR1   = 16'h0020;
    localparam logic [15:0] E_CR    = 16'h0040;
    localparam logic [15:0] E_DR2   = 16'h0080;
    localparam logic [15:0] E_ALURE = 16'h0100;
    localparam logic [15:0] E_ALUAD = 16'h0200;
    localparam logic [15:0] E_NULL2 = 16'h0400;
    localparam logic [15:0] E_NULL3 = 16'h0800;
    localparam logic [15:0] E_MPC   = 16'h1000;
    localparam logic [15:0] E_MAR   = 16'h2000;
    localparam logic [15:0] E_MOTH  = 16'h4000;
    localparam logic [15:0] E_MNULL = 16'h8000;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] ien, oen;
    logic [7:0]  alu_re;
    logic [7:0]  ins, alu_a, alu_b, alu_op, mem_addr, mem_wdata, mem_rdata;
    logic        mem_req, mem_we, mem_ack, busy, err;

    typedef struct {
        logic [15:0] oen;
        logic [15:0] ien;
        logic [7:0]  alu;
        logic [7:0]  ins;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [7:0]  op;
    } vec_t;

    typedef struct {
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
    } mem_exp_t;

    vec_t     vecs[18];
    vec_t     vec_q[$];
    mem_exp_t mem_q[$];
    int       n_cmp = 0;
    int       n_fail = 0;

    core_datapath #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_unit_ien  (ien),
        .i_unit_oen  (oen),
        .i_alu_re    (alu_re),
        .o_ins       (ins),
        .o_alu_a     (alu_a),
        .o_alu_b     (alu_b),
        .o_alu_op    (alu_op),
        .o_mem_addr  (mem_addr),
        .o_mem_req   (mem_req),
        .o_mem_we    (mem_we),
        .o_mem_wdata (mem_wdata),
        .i_mem_ack   (mem_ack),
        .i_mem_rdata (mem_rdata),
        .o_busy      (busy),
        .o_err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle();
        oen    = E_NULL;
        ien    = E_NULL;
        alu_re = 8'hEE;
    endtask

    // One enable word pair for one edge; returns at the following negedge.
    task automatic apply(input logic [15:0] o, input logic [15:0] i, input logic [7:0] alu);
        oen    = o;
        ien    = i;
        alu_re = alu;
        @(negedge clk);
        idle();
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        mem_ack = 1'b0;
        idle();
        repeat (2) @(negedge clk);
        chk("rst ins", ins, 0);
        chk("rst alu_a", alu_a, 0);
        chk("rst alu_b", alu_b, 0);
        chk("rst alu_op", alu_op, 0);
        chk("rst wdata", mem_wdata, 0);
        chk("rst req", mem_req, 0);
        chk("rst we", mem_we, 0);
        chk("rst busy", busy, 0);
        chk("rst err", err, 0);
        rst = 1'b0;
    endtask

    // Issue a memory transfer, ack it in busy cycle 'delay', check port behaviour.
    task automatic mem_op(input logic [15:0] o, input logic [15:0] i, input logic [7:0] alu,
                          input logic ewe, input logic [7:0] eaddr, input logic [7:0] ewd,
                          input logic [7:0] rdata, input int delay, input bit noise);
        mem_exp_t e;
        int       cnt;
        mem_exp_t m;
        m.we = ewe;
        m.addr = eaddr;
        m.wdata = ewd;
        mem_q.push_back(m);
        e = m;
        oen    = o;
        ien    = i;
        alu_re = alu;
        @(negedge clk);
        idle();
        cnt = 0;
        while (busy && cnt < 20) begin
            cnt++;
            if (cnt == 1 && mem_q.size() > 0) begin
                e = mem_q.pop_front();
                chk("req raised", mem_req, 1);
                chk("req we", mem_we, e.we);
                chk("req addr", mem_addr, e.addr);
                if (e.we) chk("req wdata", mem_wdata, e.wdata);
            end else begin
                chk("hold req", mem_req, 1);
                chk("hold addr", mem_addr, e.addr);
            end
            mem_ack   = (cnt == delay);
            mem_rdata = rdata;
            if (noise) begin
                oen    = E_ALURE;
                alu_re = 8'hDD;
                ien    = cnt[0] ? E_IR : 16'h0006;
            end
            @(negedge clk);
        end
        mem_ack = 1'b0;
        idle();
        chk("busy cycles", cnt, delay);
        chk("req dropped", mem_req, 0);
    endtask

    initial begin
        vec_t v;
        // oen, ien, alu_re -> expected ins, alu_a, alu_b, alu_op
        vecs[0]  = '{E_ALURE, E_DR0,   8'h12, 8'h00, 8'h12, 8'h00, 8'h00};
        vecs[1]  = '{E_DR0,   E_DR1,   8'hEE, 8'h00, 8'h12, 8'h12, 8'h00};
        vecs[2]  = '{E_ALURE, E_IR,    8'hA5, 8'hA5, 8'h12, 8'h12, 8'h00};
        vecs[3]  = '{E_ALURE, E_ALUAD, 8'h3C, 8'hA5, 8'h12, 8'h12, 8'h3C};
        vecs[4]  = '{E_ALURE, E_CR,    8'h77, 8'hA5, 8'h12, 8'h12, 8'h3C};
        vecs[5]  = '{E_CR,    E_DR0,   8'hEE, 8'hA5, 8'h77, 8'h12, 8'h3C};
        vecs[6]  = '{E_ALURE, E_DR2,   8'h33, 8'hA5, 8'h77, 8'h12, 8'h3C};
        vecs[7]  = '{E_DR2,   E_DR1,   8'hEE, 8'hA5, 8'h77, 8'h33, 8'h3C};
        vecs[8]  = '{E_ALURE, E_AR,    8'h40, 8'hA5, 8'h77, 8'h33, 8'h3C};
        vecs[9]  = '{E_AR,    E_IR,    8'hEE, 8'h40, 8'h77, 8'h33, 8'h3C};
        vecs[10] = '{E_ALURE, E_PC,    8'hFF, 8'h40, 8'h77, 8'h33, 8'h3C};
        vecs[11] = '{E_PC,    E_DR0,   8'hEE, 8'h40, 8'hFF, 8'h33, 8'h3C};
        vecs[12] = '{E_ALUAD, E_DR1,   8'hEE, 8'h40, 8'hFF, 8'h00, 8'h3C};
        vecs[13] = '{E_NULL2, E_DR0,   8'hEE, 8'h40, 8'h00, 8'h00, 8'h3C};
        vecs[14] = '{E_IR,    E_NULL3, 8'hEE, 8'h40, 8'h00, 8'h00, 8'h3C};
        vecs[15] = '{E_DR1,   E_ALURE, 8'hEE, 8'h40, 8'h00, 8'h00, 8'h3C};
        vecs[16] = '{E_MOTH,  E_IR,    8'hEE, 8'h00, 8'h00, 8'h00, 8'h3C};
        vecs[17] = '{E_IR,    E_MNULL, 8'hEE, 8'h00, 8'h00, 8'h00, 8'h3C};

        mem_rdata = 8'h00;
        do_reset();

        // Fetch from PC into IR, ack in second busy cycle; PC steps to 1.
        mem_op(E_MPC, E_IR, 8'hEE, 1'b0, 8'h00, 8'h00, 8'h5A, 2, 1'b0);
        chk("fetch ins", ins, 8'h5A);
        apply(E_PC, E_DR1, 8'hEE);
        chk("fetch pc", alu_b, 8'h01);

        do_reset();
        for (int k = 0; k < 18; k++) begin
            vec_q.push_back(vecs[k]);
            apply(vecs[k].oen, vecs[k].ien, vecs[k].alu);
            v = vec_q.pop_front();
            chk($sformatf("v%0d ins", k), ins, v.ins);
            chk($sformatf("v%0d alu_a", k), alu_a, v.a);
            chk($sformatf("v%0d alu_b", k), alu_b, v.b);
            chk($sformatf("v%0d alu_op", k), alu_op, v.op);
            chk($sformatf("v%0d req", k), mem_req, 0);
            chk($sformatf("v%0d err", k), err, 0);
        end

        // PC=FF: read wraps PC; enables driven while busy must be ignored.
        mem_op(E_MPC, E_IR, 8'hEE, 1'b0, 8'hFF, 8'h00, 8'h5A, 2, 1'b1);
        chk("wrap ins", ins, 8'h5A);
        chk("busy ignore err", err, 0);
        mem_op(E_MPC, E_DR1, 8'hEE, 1'b0, 8'h00, 8'h00, 8'hC3, 1, 1'b0);
        chk("wrap rd b", alu_b, 8'hC3);
        // Writes through AR (no PC step) and PC (PC steps).
        mem_op(E_DR2, E_MAR, 8'hEE, 1'b1, 8'h40, 8'h33, 8'h00, 3, 1'b0);
        mem_op(E_DR1, E_MPC, 8'hEE, 1'b1, 8'h01, 8'hC3, 8'h00, 2, 1'b0);
        mem_op(E_MAR, E_ALUAD, 8'hEE, 1'b0, 8'h40, 8'h00, 8'h99, 1, 1'b0);
        chk("rd op", alu_op, 8'h99);
        // Loading PC from memory beats the auto-increment.
        mem_op(E_MPC, E_PC, 8'hEE, 1'b0, 8'h02, 8'h00, 8'h80, 2, 1'b0);
        apply(E_PC, E_DR0, 8'hEE);
        chk("pc load", alu_a, 8'h80);
        mem_op(E_ALURE, E_MAR, 8'h6B, 1'b1, 8'h40, 8'h6B, 8'h00, 1, 1'b0);
        mem_op(E_MPC, E_AR, 8'hEE, 1'b0, 8'h80, 8'h00, 8'h10, 1, 1'b0);
        mem_op(E_MAR, E_DR0, 8'hEE, 1'b0, 8'h10, 8'h00, 8'h07, 2, 1'b0);
        chk("ar rd a", alu_a, 8'h07);
        apply(E_PC, E_DR1, 8'hEE);
        chk("pc after ar rd", alu_b, 8'h81);

        // Two target bits: error, nothing written.
        do_reset();
        apply(E_ALURE, 16'h0006, 8'h11);
        chk("2hot err", err, 1);
        chk("2hot ins", ins, 8'h00);
        apply(E_PC, E_DR0, 8'hEE);
        chk("2hot pc", alu_a, 8'h00);
        // Memory to memory: error, no request.
        do_reset();
        apply(E_MAR, E_MPC, 8'hEE);
        chk("m2m err", err, 1);
        chk("m2m req", mem_req, 0);
        chk("m2m busy", busy, 0);
        // Zero source word: error, sticky across later legal moves.
        do_reset();
        apply(16'h0000, E_DR0, 8'h55);
        chk("zero err", err, 1);
        apply(E_ALURE, E_DR0, 8'h05);
        chk("sticky a", alu_a, 8'h05);
        chk("sticky err", err, 1);

        // Reset during a read with ack in the same cycle abandons the transfer.
        do_reset();
        apply(E_ALURE, E_IR, 8'h21);
        chk("pre ins", ins, 8'h21);
        oen = E_MPC;
        ien = E_IR;
        @(negedge clk);
        idle();
        chk("abort busy", busy, 1);
        mem_ack   = 1'b1;
        mem_rdata = 8'hEE;
        rst       = 1'b1;
        @(negedge clk);
        rst     = 1'b0;
        mem_ack = 1'b0;
        chk("abort req", mem_req, 0);
        chk("abort busy0", busy, 0);
        chk("abort ins", ins, 8'h00);
        apply(E_PC, E_DR0, 8'hEE);
        chk("abort pc", alu_a, 8'h00);
        apply(E_ALURE, E_DR1, 8'h44);
        chk("post rst b", alu_b, 8'h44);

        chk("mem queue empty", mem_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running, want finished");
        $fatal(1);
    end

endmodule
